// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the 3-bit ALU sequencing controller: opcodes, FSM states,
// command word layout and opcode legality.
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_OR  = 3'b000,
      OP_AND = 3'b001,
      OP_XOR = 3'b010,
      OP_ADD = 3'b011,
      OP_SUB = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int WORD_W = 9;
   localparam int OP_MSB = 8;
   localparam int OP_LSB = 6;

   // The ALU mux decodes only the first five codes; 101..111 fall through to garbage.
   function automatic logic op_is_valid(input logic [2:0] op);
      return op <= OP_SUB;
   endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last requester that won.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       take,
   output logic [1:0] grant
);

   logic last;

   always_comb begin
      grant = valid;
      if (valid == 2'b11)
         grant = last ? 2'b01 : 2'b10;
   end

   // Pointer only moves on a real handshake so an idle cycle never steals a turn.
   always_ff @(posedge clk) begin
      if (!rst_n)
         last <= 1'b1;
      else if (take && (grant != 2'b00))
         last <= grant[1];
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto the shared 3-bit ALU: one settle cycle on alu_in,
// registered result capture, tagged response with backpressure, completion counter.
module alu_share_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid,
   input  logic [WORD_W-1:0]    req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [WORD_W-1:0]    req1_data,
   output logic                 req1_ready,
   output logic [WORD_W-1:0]    alu_in,
   input  logic [2:0]           alu_z,
   input  logic                 alu_cout,
   input  logic                 alu_ovf,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 resp_id,
   output logic [2:0]           resp_z,
   output logic                 resp_cout,
   output logic                 resp_ovf,
   output logic                 resp_err,
   output logic [CNT_W-1:0]     ops_done
);

   state_e            state, state_nxt;
   logic [1:0]        grant;
   logic [1:0]        arb_valid;
   logic              take;
   logic              word_ok;
   logic [WORD_W-1:0] word;

   assign arb_valid = {req1_valid, req0_valid} & {2{rst_n && (state == IDLE)}};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .valid (arb_valid),
      .take  (take),
      .grant (grant)
   );

   assign take       = |grant;
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign word       = grant[1] ? req1_data : req0_data;
   assign word_ok    = op_is_valid(word[OP_MSB:OP_LSB]);
   assign resp_valid = (state == RESP);

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = word_ok ? EXEC : RESP;
         EXEC:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Rejected opcodes never touch alu_in, so the display keeps the last real operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_in    <= '0;
         resp_id   <= 1'b0;
         resp_z    <= 3'b000;
         resp_cout <= 1'b0;
         resp_ovf  <= 1'b0;
         resp_err  <= 1'b0;
         ops_done  <= '0;
      end else begin
         case (state)
            IDLE: if (take) begin
               resp_id <= grant[1];
               if (word_ok) begin
                  alu_in <= word;
               end else begin
                  resp_z    <= 3'b000;
                  resp_cout <= 1'b0;
                  resp_ovf  <= 1'b0;
                  resp_err  <= 1'b1;
               end
            end
            EXEC: begin
               resp_z    <= alu_z;
               resp_cout <= alu_cout;
               resp_ovf  <= alu_ovf;
               resp_err  <= 1'b0;
            end
            RESP: if (resp_ready) ops_done <= ops_done + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios then random traffic,
// scored against a transaction-level model (pending-response queue plus latency).
module tb_alu_share_ctrl;

   localparam int CNT_W = 2;

   typedef struct {
      int         id;
      logic [2:0] z;
      logic       c;
      logic       v;
      logic       e;
      int         due;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req0_valid = 1'b0, req1_valid = 1'b0;
   logic [8:0]       req0_data = '0, req1_data = '0;
   logic             req0_ready, req1_ready;
   logic [8:0]       alu_in;
   logic [2:0]       alu_z;
   logic             alu_cout, alu_ovf;
   logic             resp_valid, resp_id, resp_cout, resp_ovf, resp_err;
   logic             resp_ready = 1'b0;
   logic [2:0]       resp_z;
   logic [CNT_W-1:0] ops_done;

   int         n_assert = 0, n_fail = 0;
   int         cyc_n = 0, last_id = 1, cnt_m = 0, acc_id = -1;
   logic       rdone = 1'b0;
   logic [8:0] exp_alu_in = '0;
   rsp_t       pend[$];
   int         gnt_log[$];
   int         wrap_seq[5] = '{1, 2, 3, 0, 1};

   always #5 clk = ~clk;

   alu_share_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .alu_in     (alu_in),
      .alu_z      (alu_z),
      .alu_cout   (alu_cout),
      .alu_ovf    (alu_ovf),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_z     (resp_z),
      .resp_cout  (resp_cout),
      .resp_ovf   (resp_ovf),
      .resp_err   (resp_err),
      .ops_done   (ops_done)
   );

   // Stand-in for the external ALU, written as plain integer arithmetic.
   function automatic logic [4:0] alu_eval(input logic [8:0] w);
      int a, b, sa, sb, r, s;
      logic c, v;
      a = int'(w[5:3]);
      b = int'(w[2:0]);
      sa = (a > 3) ? a - 8 : a;
      sb = (b > 3) ? b - 8 : b;
      r = 0; s = 0; c = 1'b0; v = 1'b0;
      case (w[8:6])
         3'd0: r = a | b;
         3'd1: r = a & b;
         3'd2: r = a ^ b;
         3'd3: begin r = a + b;     s = sa + sb; c = (r > 7); v = (s > 3) || (s < -4); end
         3'd4: begin r = a - b + 8; s = sa - sb; c = (r > 7); v = (s > 3) || (s < -4); end
         default: r = 0;
      endcase
      return {v, c, r[2:0]};
   endfunction

   assign {alu_ovf, alu_cout, alu_z} = alu_eval(alu_in);

   function automatic logic [8:0] rnd_ok();
      return {3'($urandom_range(0, 4)), 6'($urandom)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: score outputs at the falling edge, advance the model to the rising edge.
   task automatic step();
      logic [1:0] v, er;
      logic       rv;
      rsp_t       t;
      logic [8:0] w;
      @(negedge clk);
      v  = {req1_valid, req0_valid};
      er = 2'b00;
      if (rst_n && pend.size() == 0)
         er = (v == 2'b11) ? ((last_id == 1) ? 2'b01 : 2'b10) : v;
      check("ready", {req1_ready, req0_ready}, er);
      rv = 1'b0;
      if (pend.size() != 0) rv = (cyc_n >= pend[0].due);
      check("resp_valid", resp_valid, rv);
      if (rv) begin
         t = pend[0];
         check("resp_id", resp_id, t.id);
         check("resp_z", resp_z, t.z);
         check("resp_cout", resp_cout, t.c);
         check("resp_ovf", resp_ovf, t.v);
         check("resp_err", resp_err, t.e);
      end
      check("alu_in", alu_in, exp_alu_in);
      check("ops_done", ops_done, cnt_m);
      acc_id = -1;
      rdone  = 1'b0;
      if (!rst_n) begin
         pend.delete();
         cnt_m = 0; last_id = 1; exp_alu_in = '0;
      end else begin
         if (rv && resp_ready) begin
            void'(pend.pop_front());
            cnt_m = (cnt_m + 1) % (1 << CNT_W);
            rdone = 1'b1;
         end
         if (er != 2'b00) begin
            acc_id = er[1] ? 1 : 0;
            w = er[1] ? req1_data : req0_data;
            last_id = acc_id;
            gnt_log.push_back(acc_id);
            t.id = acc_id;
            if (w[8:6] <= 3'd4) begin
               {t.v, t.c, t.z} = alu_eval(w);
               t.e = 1'b0; t.due = cyc_n + 2; exp_alu_in = w;
            end else begin
               t.z = 3'b000; t.c = 1'b0; t.v = 1'b0; t.e = 1'b1; t.due = cyc_n + 1;
            end
            pend.push_back(t);
         end
      end
      @(posedge clk);
      cyc_n++;
      #1;
   endtask

   task automatic send(input int id, input logic [8:0] w);
      if (id == 0) begin req0_valid = 1'b1; req0_data = w; end
      else         begin req1_valid = 1'b1; req1_data = w; end
      for (int i = 0; i < 30; i++) begin
         step();
         if (acc_id == id) break;
      end
      check("send_accepted", acc_id, id);
      if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
   endtask

   task automatic wait_resp();
      for (int i = 0; i < 30 && pend.size() != 0; i++) step();
      check("resp_drained", pend.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a requester waiting: no ready, all outputs cleared.
      rst_n = 1'b0; req0_valid = 1'b1; req0_data = 9'b011_011_001;
      repeat (3) step();
      check("rst_ready0", req0_ready, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_fields", {resp_id, resp_z, resp_cout, resp_ovf, resp_err}, 7'd0);
      check("rst_alu_in", alu_in, 9'd0);
      check("rst_ops_done", ops_done, 0);
      req0_valid = 1'b0; rst_n = 1'b1; resp_ready = 1'b1;
      step();

      // Single ADD 3+1: overflow, response two edges after accept.
      send(0, 9'b011_011_001);
      check("add_exec_no_resp", resp_valid, 1'b0);
      check("add_alu_in", alu_in, 9'b011_011_001);
      step();
      check("add_resp_valid", resp_valid, 1'b1);
      check("add_resp_id", resp_id, 1'b0);
      check("add_resp_z", resp_z, 3'b100);
      check("add_resp_ovf", resp_ovf, 1'b1);
      check("add_resp_err", resp_err, 1'b0);
      step();
      check("add_ops_done", ops_done, 1);

      // Invalid opcode: immediate error response, alu_in untouched.
      send(1, 9'b110_001_001);
      check("inv_resp_valid", resp_valid, 1'b1);
      check("inv_resp_err", resp_err, 1'b1);
      check("inv_resp_z", resp_z, 3'b000);
      check("inv_resp_id", resp_id, 1'b1);
      check("inv_alu_in", alu_in, 9'b011_011_001);
      step();
      check("inv_ops_done", ops_done, 2);

      // Tie fairness: both requesters hold valid across four commands.
      gnt_log.delete();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = rnd_ok(); req1_data = rnd_ok();
      for (int i = 0; i < 40 && gnt_log.size() < 4; i++) begin
         step();
         check("tie_ready_excl", req0_ready & req1_ready, 1'b0);
         if (acc_id == 0) req0_data = rnd_ok();
         if (acc_id == 1) req1_data = rnd_ok();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("tie_count", gnt_log.size(), 4);
      for (int i = 0; i < gnt_log.size(); i++) check("tie_order", gnt_log[i], i % 2);
      wait_resp();

      // Backpressure: SUB 2-3 held at 111 while the consumer stalls.
      resp_ready = 1'b0;
      send(0, 9'b100_010_011);
      req1_valid = 1'b1; req1_data = 9'b000_101_010;
      step();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", resp_valid, 1'b1);
         check("bp_z", resp_z, 3'b111);
         check("bp_readys", {req1_ready, req0_ready}, 2'b00);
         step();
      end
      resp_ready = 1'b1;
      step();
      check("bp_released", resp_valid, 1'b0);
      for (int i = 0; i < 10 && acc_id != 1; i++) step();
      check("bp_req1_acc", acc_id, 1);
      req1_valid = 1'b0;
      wait_resp();

      // Reset during EXEC drops the command; first tie afterwards goes to requester 0.
      send(1, 9'b011_001_001);
      rst_n = 1'b0;
      step();
      check("mid_rst_resp_valid", resp_valid, 1'b0);
      check("mid_rst_alu_in", alu_in, 9'd0);
      check("mid_rst_ops_done", ops_done, 0);
      rst_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = rnd_ok(); req1_data = rnd_ok();
      for (int i = 0; i < 10 && acc_id < 0; i++) step();
      check("mid_rst_first_tie", acc_id, 0);
      req0_valid = 1'b0;
      for (int i = 0; i < 20 && acc_id != 1; i++) step();
      check("mid_rst_req1_acc", acc_id, 1);
      req1_valid = 1'b0;
      wait_resp();

      // Counter wrap at CNT_W=2, error responses included.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(i % 2, (i == 2) ? {3'b111, 6'($urandom)} : rnd_ok());
         wait_resp();
         check("wrap_ops_done", ops_done, wrap_seq[i]);
      end

      // Random traffic with stalls and occasional resets.
      for (int n = 0; n < 1500; n++) begin
         if (acc_id == 0 || !req0_valid) begin
            req0_valid = ($urandom_range(0, 2) != 0); req0_data = 9'($urandom);
         end
         if (acc_id == 1 || !req1_valid) begin
            req1_valid = ($urandom_range(0, 2) != 0); req1_data = 9'($urandom);
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         rst_n      = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      wait_resp();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
